grid_painter: RTL and testbench

//  Command-driven writer for the GridData dual-port RAM (64x48 cells, 4-bit colour index per cell).
//  It sits directly upstream of the VGA read path and drives the RAM's write port (wraddress/wren/data).

---
 rtl/grid_painter.sv | 198 +++++++++++++++++++
 tb/tb_grid_painter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_painter.sv
// -----------------------------------------------------------------------------
// grid_painter
//   Command-driven writer for the GridData dual-port RAM (64x48 cells, 4-bit
//   colour index per cell). Game logic hands over SET / FILL / CLEAR commands
//   on a valid/ready handshake. Each command is expanded into one cell write
//   per iVGA_CLK cycle, in row-major order, on the RAM's write port. The read
//   side of the RAM, which is used by the VGA scan-out, is not touched.
//
// Ports
//   iVGA_CLK   in   clock, shared with the GridData read side
//   iRST_n     in   asynchronous reset, active-low
//   cmd_valid  in   a command is present
//   cmd_ready  out  a command can be accepted (high only while idle)
//   cmd_op     in   00 NOP, 01 SET cell, 10 FILL rectangle, 11 CLEAR grid
//   cmd_x0/y0  in   corner A (the cell for SET)
//   cmd_x1/y1  in   corner B (FILL only)
//   cmd_color  in   colour index to write
//   wraddress  out  GridData write address, y*GRID_W + x
//   wren       out  GridData write enable
//   data       out  GridData write data
//   busy       out  high while a command is being processed
//   done       out  one-cycle pulse after the last write (or after a NOP)
// -----------------------------------------------------------------------------
module grid_painter #(
  parameter int GRID_W  = 64,
  parameter int GRID_H  = 48,
  parameter int COLOR_W = 4,
  parameter int ADDR_W  = 12
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_x0,
  input  logic [5:0]         cmd_y0,
  input  logic [5:0]         cmd_x1,
  input  logic [5:0]         cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [ADDR_W-1:0]  wraddress,
  output logic               wren,
  output logic [COLOR_W-1:0] data,
  output logic               busy,
  output logic               done
);

  localparam int         XBITS = $clog2(GRID_W);
  localparam logic [5:0] X_MAX = 6'(GRID_W - 1);
  localparam logic [5:0] Y_MAX = 6'(GRID_H - 1);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PAINT  = 2'b01,
    FINISH = 2'b10
  } state_t;

  state_t             state_q, state_d;
  // Cursor: the cell currently presented on the write port.
  logic [5:0]         cx_q, cx_d;
  logic [5:0]         cy_q, cy_d;
  // Normalised rectangle bounds; the start row is only needed at accept time.
  logic [5:0]         xs_q, xs_d;
  logic [5:0]         xe_q, xe_d;
  logic [5:0]         ye_q, ye_d;
  logic               wren_q, wren_d;
  logic [COLOR_W-1:0] data_q, data_d;

  // Rectangle derived from the command fields currently on the inputs.
  logic [5:0]         y0_clamped, y1_clamped;
  logic [5:0]         rect_xs, rect_xe, rect_ys, rect_ye;
  logic               last_cell;

  // ---------------------------------------------------------------------------
  // Command decode: normalise corners into start/end bounds. Rows beyond the
  // bottom of the grid are pulled back to the last row; columns are 6 bits and
  // therefore always inside a 64-wide grid.
  // ---------------------------------------------------------------------------
  always_comb begin
    y0_clamped = (cmd_y0 > Y_MAX) ? Y_MAX : cmd_y0;
    y1_clamped = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
    rect_xs    = cmd_x0;
    rect_xe    = cmd_x0;
    rect_ys    = y0_clamped;
    rect_ye    = y0_clamped;
    case (cmd_op)
      OP_FILL: begin
        rect_xs = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
        rect_xe = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
        rect_ys = (y0_clamped < y1_clamped) ? y0_clamped : y1_clamped;
        rect_ye = (y0_clamped < y1_clamped) ? y1_clamped : y0_clamped;
      end
      OP_CLEAR: begin
        rect_xs = 6'd0;
        rect_xe = X_MAX;
        rect_ys = 6'd0;
        rect_ye = Y_MAX;
      end
      default: begin
        // SET (and NOP, whose bounds are never used) keep corner A.
      end
    endcase
  end

  assign last_cell = (cx_q == xe_q) && (cy_q == ye_q);

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    wren_d  = 1'b0;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          data_d = cmd_color;
          if (cmd_op == OP_NOP) begin
            state_d = FINISH;
          end else begin
            // The first cell goes out on the very next cycle.
            state_d = PAINT;
            wren_d  = 1'b1;
            cx_d    = rect_xs;
            cy_d    = rect_ys;
            xs_d    = rect_xs;
            xe_d    = rect_xe;
            ye_d    = rect_ye;
          end
        end
      end

      PAINT: begin
        if (last_cell) begin
          state_d = FINISH;
        end else begin
          wren_d = 1'b1;
          if (cx_q == xe_q) begin
            cx_d = xs_q;
            cy_d = cy_q + 6'd1;
          end else begin
            cx_d = cx_q + 6'd1;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      xs_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      wren_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      wren_q  <= wren_d;
      data_q  <= data_d;
    end
  end

  // GRID_W is a power of two, so y*GRID_W + x is a plain bit concatenation of
  // the cursor registers.
  assign wraddress = (ADDR_W'(cy_q) << XBITS) | ADDR_W'(cx_q);
  assign wren      = wren_q;
  assign data      = data_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);

endmodule

// File: tb/tb_grid_painter.sv
// -----------------------------------------------------------------------------
// tb_grid_painter
//   Self-checking bench for grid_painter. A behavioural model turns every
//   accepted command into the list of cell addresses it must write, and the
//   DUT's write port, handshake and status outputs are compared with that list
//   on every cycle. Directed cases pin the model with hand-computed values,
//   followed by a randomized command stream.
// -----------------------------------------------------------------------------
module tb_grid_painter;

  logic        iVGA_CLK = 1'b0;
  logic        iRST_n   = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op    = 2'b00;
  logic [5:0]  cmd_x0    = '0;
  logic [5:0]  cmd_y0    = '0;
  logic [5:0]  cmd_x1    = '0;
  logic [5:0]  cmd_y1    = '0;
  logic [3:0]  cmd_color = '0;
  logic [11:0] wraddress;
  logic        wren;
  logic [3:0]  data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 iVGA_CLK = ~iVGA_CLK;

  grid_painter dut (
    .iVGA_CLK  (iVGA_CLK),
    .iRST_n    (iRST_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .wraddress (wraddress),
    .wren      (wren),
    .data      (data),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a queue of the addresses still to be written. Head of
  // the queue is the write expected on the port during the current cycle.
  // ---------------------------------------------------------------------------
  int exp_q[$];
  bit m_fin   = 1'b0;
  int m_color = 0;

  always @(posedge iVGA_CLK or negedge iRST_n) begin
    int y0, y1, xs, xe, ys, ye;
    if (!iRST_n) begin
      exp_q.delete();
      m_fin = 1'b0;
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) m_fin = 1'b1;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (cmd_valid) begin
      m_color = int'(cmd_color);
      y0 = (int'(cmd_y0) > 47) ? 47 : int'(cmd_y0);
      y1 = (int'(cmd_y1) > 47) ? 47 : int'(cmd_y1);
      xs = int'(cmd_x0); xe = int'(cmd_x0); ys = y0; ye = y0;
      if (cmd_op == 2'b10) begin
        xs = (cmd_x0 < cmd_x1) ? int'(cmd_x0) : int'(cmd_x1);
        xe = (cmd_x0 < cmd_x1) ? int'(cmd_x1) : int'(cmd_x0);
        ys = (y0 < y1) ? y0 : y1;
        ye = (y0 < y1) ? y1 : y0;
      end else if (cmd_op == 2'b11) begin
        xs = 0; xe = 63; ys = 0; ye = 47;
      end
      if (cmd_op == 2'b00) begin
        m_fin = 1'b1;
      end else begin
        for (int y = ys; y <= ye; y++)
          for (int x = xs; x <= xe; x++)
            exp_q.push_back(y * 64 + x);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge iVGA_CLK) begin
    bit mw;
    bit mb;
    mw = (exp_q.size() > 0);
    mb = mw || m_fin;
    chk("wren", int'(wren), int'(mw));
    chk("done", int'(done), int'(m_fin));
    chk("busy", int'(busy), int'(mb));
    chk("cmd_ready", int'(cmd_ready), int'(!mb));
    if (mw) begin
      chk("wraddress", int'(wraddress), exp_q[0]);
      chk("data", int'(data), m_color);
    end
  end

  // ---------------------------------------------------------------------------
  // Write log and cycle bookkeeping for the directed literal checks.
  // ---------------------------------------------------------------------------
  int wr_log[$];
  int wd_log[$];
  int cyc      = 0;
  int done_cyc = 0;
  int acc_cyc  = 0;

  always @(posedge iVGA_CLK) cyc++;

  always @(negedge iVGA_CLK) begin
    if (wren) begin
      wr_log.push_back(int'(wraddress));
      wd_log.push_back(int'(data));
    end
    if (done) done_cyc = cyc;
  end

  task automatic drive_random();
    cmd_valid = 1'b1;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_x0    = 6'($urandom_range(0, 63));
    cmd_y0    = 6'($urandom_range(0, 63));
    cmd_x1    = 6'($urandom_range(0, 63));
    cmd_y1    = 6'($urandom_range(0, 63));
    cmd_color = 4'($urandom_range(0, 15));
  endtask

  // Present a command on the first cmd_ready cycle; with jitter, random fields
  // are held on a valid bus while the DUT is busy, before and after.
  // Returns on the first negedge after the accepting edge.
  task automatic send(input int op, input int x0, input int y0, input int x1,
                      input int y1, input int col, input bit jitter);
    bit ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge iVGA_CLK);
      if (cmd_ready) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_x0    = 6'(x0);
        cmd_y0    = 6'(y0);
        cmd_x1    = 6'(x1);
        cmd_y1    = 6'(y1);
        cmd_color = 4'(col);
        ok = 1'b1;
        break;
      end else if (jitter) begin
        drive_random();
      end
    end
    chk("accept_timeout", int'(ok), 1);
    @(negedge iVGA_CLK);
    acc_cyc = cyc;
    if (jitter) drive_random();
    else cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge iVGA_CLK);
    end
    chk("done_timeout", int'(ok), 1);
    @(negedge iVGA_CLK);
  endtask

  task automatic clear_logs();
    wr_log.delete();
    wd_log.delete();
  endtask

  initial begin
    int fill_exp[6];
    int clamp_exp[4];
    int bad;
    int op;
    int clears;
    bit jit;

    fill_exp  = '{136, 137, 138, 200, 201, 202};
    clamp_exp = '{2944, 2945, 3008, 3009};

    // Reset state
    repeat (3) @(negedge iVGA_CLK);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_wren", int'(wren), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wraddress", int'(wraddress), 0);
    chk("rst_data", int'(data), 0);
    iRST_n = 1'b1;
    repeat (2) @(negedge iVGA_CLK);

    // SET (5,3) colour 7
    clear_logs();
    send(1, 5, 3, 0, 0, 7, 1'b0);
    wait_done();
    chk("set_count", wr_log.size(), 1);
    if (wr_log.size() > 0) begin
      chk("set_addr", wr_log[0], 197);
      chk("set_data", wd_log[0], 7);
    end
    chk("set_done_cycle", done_cyc - acc_cyc + 1, 2);
    $display("SET   x=5 y=3 col=7 writes=%0d", wr_log.size());

    // FILL with swapped corners
    clear_logs();
    send(2, 10, 2, 8, 3, 2, 1'b0);
    wait_done();
    chk("fill_count", wr_log.size(), 6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++) begin
      chk("fill_addr", wr_log[i], fill_exp[i]);
      chk("fill_data", wd_log[i], 2);
    end
    $display("FILL  (10,2)-(8,3) col=2 writes=%0d", wr_log.size());

    // CLEAR
    clear_logs();
    send(3, 0, 0, 0, 0, 0, 1'b0);
    wait_done();
    chk("clear_count", wr_log.size(), 3072);
    bad = 0;
    for (int i = 0; i < wr_log.size(); i++)
      if (wr_log[i] != i) bad++;
    chk("clear_order", bad, 0);
    chk("clear_done_cycle", done_cyc - acc_cyc + 1, 3073);
    $display("CLEAR col=0 writes=%0d", wr_log.size());

    // FILL with an off-grid row, clamped to row 47
    clear_logs();
    send(2, 1, 46, 0, 60, 9, 1'b0);
    wait_done();
    chk("clamp_count", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      chk("clamp_addr", wr_log[i], clamp_exp[i]);
    $display("FILL  (1,46)-(0,60) col=9 writes=%0d", wr_log.size());

    // NOP
    clear_logs();
    send(0, 7, 7, 7, 7, 3, 1'b0);
    wait_done();
    chk("nop_count", wr_log.size(), 0);
    chk("nop_done_cycle", done_cyc - acc_cyc + 1, 1);
    $display("NOP   writes=%0d", wr_log.size());

    // Reset in the middle of a FILL, after three writes
    clear_logs();
    send(2, 0, 0, 63, 10, 5, 1'b0);
    repeat (2) @(negedge iVGA_CLK);
    #2 iRST_n = 1'b0;
    #1;
    chk("midrst_wren", int'(wren), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_wraddress", int'(wraddress), 0);
    repeat (2) @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    repeat (5) @(negedge iVGA_CLK);
    chk("midrst_writes", wr_log.size(), 3);
    send(1, 63, 47, 0, 0, 15, 1'b0);
    wait_done();
    chk("postrst_count", wr_log.size(), 4);
    if (wr_log.size() == 4) chk("postrst_addr", wr_log[3], 3071);
    $display("RESET mid-FILL writes_before=3 total=%0d", wr_log.size());

    // Handshake: valid held with changing fields while busy
    clear_logs();
    send(1, 1, 1, 0, 0, 3, 1'b1);
    send(0, 0, 0, 0, 0, 0, 1'b1);
    send(2, 3, 0, 2, 0, 4, 1'b0);
    wait_done();
    chk("hs_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("hs_addr0", wr_log[0], 65);
      chk("hs_addr1", wr_log[1], 2);
      chk("hs_addr2", wr_log[2], 3);
    end
    $display("HANDSHAKE SET,NOP,FILL writes=%0d", wr_log.size());

    // Randomized command stream
    clears = 0;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 3);
      if (op == 3) begin
        if (clears >= 2) op = 2;
        else clears++;
      end
      jit = (n == 59) ? 1'b0 : 1'(($urandom_range(0, 2) == 0) ? 1 : 0);
      send(op, $urandom_range(0, 63), $urandom_range(0, 63),
           $urandom_range(0, 63), $urandom_range(0, 63),
           $urandom_range(0, 15), jit);
      $display("RAND  n=%0d op=%0d x0=%0d y0=%0d x1=%0d y1=%0d col=%0d", n, op,
               cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color);
      if (!jit) repeat ($urandom_range(0, 3)) @(negedge iVGA_CLK);
    end
    wait_done();
    repeat (3) @(negedge iVGA_CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
